uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmitter between four byte requesters: the result-readout controller, the status reporter and two debug sources. Each requester presents a byte with a request and receives a one-cycle acknowledge when the byte is handed to the UART. Multi-byte packets are kept contiguous: a requester keeps the grant until it sends a byte flagged `last`. The block sits between the requesters and the UART TX `in`/`busy` handshake.

## Interface
- `TIMEOUT`, 255, idle cycles a locked owner may hold the grant without requesting (8-bit counter; legal 1..255).
- `clk`  in  1  clock.
- `nRst`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester byte request; level, held until acked.
- `last`  in  4  per-requester end-of-packet flag, qualified by `req`.
- `data_in`  in  32  requester k byte on bits [8k+7:8k].
- `uart_busy`  in  1  UART TX busy.
- `ack`  out  4  one-cycle pulse: byte of requester k accepted.
- `grant`  out  4  one-hot current owner; 0 when free.
- `uart_data`  out  8  byte to UART.
- `uart_in`  out  1  one-cycle UART load strobe.
- `timeout`  out  1  sticky: a lock was released by timeout.

## Operation
- States: IDLE, SEND, HOLD, WAIT, LOCK.
- IDLE: if `req` nonzero, pick winner by round-robin starting at `ptr` (2-bit, points to highest-priority index); register `grant`, `uart_data` = winner byte, `uart_in`=1, `ack[winner]`=1; -> SEND. Latch winner's `last`.
- SEND: `uart_in`, `ack` return to 0; -> HOLD.
- HOLD: single cycle covering UART busy-assert latency; -> WAIT.
- WAIT: on `!uart_busy`: if latched `last`=1 -> IDLE, `grant`=0, `ptr` = winner+1 (mod 4); else -> LOCK, counter cleared.
- LOCK: only owner's `req` considered; others ignored. If owner `req`: load byte, strobe, ack as in IDLE, -> SEND. Else counter increments (timeout handling under Configuration).
- `req`/`last`/`data_in` sampled only in IDLE and LOCK; requester must update or drop `req` in the cycle after `ack`.
- `ptr` reset 0; requester 0 wins when all request simultaneously from reset.
- Reset values: `ack`=0, `grant`=0, `uart_data`=0, `uart_in`=0, `timeout`=0, state IDLE, `ptr`=0, counter 0. Reset mid-byte drops grant and lock; the UART byte in flight is not aborted by this block.

## Timing
- `req` high at cycle t in IDLE/LOCK -> `uart_in`, `ack` high at t+1, for exactly one cycle.
- Minimum byte period: 3 cycles + `uart_busy` high time; next strobe no earlier than cycle after `uart_busy` falls +1.
- `grant` valid from t+1 until release; changes only on IDLE entry or exit.
- `uart_busy` low during HOLD is ignored; only WAIT samples it.
- Simultaneous `req` drop and `last`: only the acked byte's `last` matters.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: in LOCK, counter reaching `TIMEOUT` with owner `req` low -> IDLE, `grant`=0, `ptr` = owner+1, `timeout` set (cleared only by reset).
- Not defined: counter absent; lock held indefinitely until owner sends `last`; `timeout` tied 0.

## Test plan
- Reset, `req`=4'b1111, all `last`=1, busy 5 cycles per byte -> acks in order 0,1,2,3, `ptr` back to 0, each `uart_in` one cycle.
- Requester 2 sends 3 bytes 0x11,0x22,0x33 (`last` on 0x33) while requester 0 requests throughout -> `grant`=4'b0100 for all three, requester 0 acked only after 0x33.
- `req[1]` with 0xA5, `uart_busy` rises 1 cycle after `uart_in` -> `uart_data`=0xA5 at t+1, no second strobe until busy falls.
- With macro, `TIMEOUT`=10: owner 3 sends non-last byte then drops `req` -> release 10 cycles after LOCK entry, `timeout`=1, requester 0 next winner.
- Without macro, same stimulus -> `grant`=4'b1000 held 1000 cycles, `timeout`=0.
- Assert `nRst` during WAIT of a locked packet -> all outputs 0 next cycle; after release, `req`=4'b0110 -> requester 1 wins.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin arbiter sharing one UART transmitter between four byte
//   requesters. A requester keeps the grant until it sends a byte flagged
//   `last`, so multi-byte packets reach the UART contiguously.
//
//   Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//     defined   : a locked owner idle for TIMEOUT cycles loses the grant and
//                 the sticky `timeout` flag is set.
//     undefined : lock is held until the owner sends `last`; `timeout` is 0.
//
// Ports
//   clk, nRst     clock, asynchronous active-low reset
//   req[3:0]      per-requester byte request (level, held until acked)
//   last[3:0]     per-requester end-of-packet flag, qualified by req
//   data_in[31:0] requester k byte on bits [8k+7:8k]
//   uart_busy     UART TX busy
//   ack[3:0]      one-cycle pulse: byte of requester k accepted
//   grant[3:0]    one-hot current owner, 0 when free
//   uart_data     byte presented to the UART
//   uart_in       one-cycle UART load strobe
//   timeout       sticky: a lock was released by timeout
module uart_tx_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [31:0] data_in,
  input  logic        uart_busy,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic [7:0]  uart_data,
  output logic        uart_in,
  output logic        timeout
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT, LOCK} state_t;

  state_t      state, state_d;
  logic [1:0]  ptr, ptr_d;
  logic [1:0]  owner, owner_d;
  logic        last_q, last_d;
  logic [3:0]  grant_d, ack_d;
  logic [7:0]  data_d;
  logic        in_d;
  logic [1:0]  win, idx, ld_idx;
  logic        found, load;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [7:0]  cnt, cnt_d;
  logic        to_d;
`endif

  // Round-robin pick: first requesting index at or after ptr.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    last_d  = last_q;
    grant_d = grant;
    data_d  = uart_data;
    ack_d   = '0;
    in_d    = 1'b0;
    load    = 1'b0;
    ld_idx  = win;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt;
    to_d    = timeout;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          load   = 1'b1;
          ld_idx = win;
        end
      end
      SEND: state_d = HOLD;
      HOLD: state_d = WAIT;
      WAIT: begin
        if (!uart_busy) begin
          if (last_q) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = owner + 2'd1;
          end else begin
            state_d = LOCK;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      LOCK: begin
        if (req[owner]) begin
          load   = 1'b1;
          ld_idx = owner;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt == 8'(TIMEOUT - 1)) begin
          // Release on the TIMEOUT-th idle cycle since LOCK entry.
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner + 2'd1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      owner_d       = ld_idx;
      grant_d       = 4'b0001 << ld_idx;
      data_d        = data_in[{ld_idx, 3'b000} +: 8];
      in_d          = 1'b1;
      ack_d[ld_idx] = 1'b1;
      last_d        = last[ld_idx];
      state_d       = SEND;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      last_q    <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      uart_data <= '0;
      uart_in   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      last_q    <= last_d;
      grant     <= grant_d;
      ack       <= ack_d;
      uart_data <= data_d;
      uart_in   <= in_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      timeout <= to_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  localparam int unsigned BUSY_LEN = 5;
  localparam int unsigned TO       = 10;

  logic        clk = 1'b0;
  logic        nRst;
  logic [3:0]  req, last;
  logic [31:0] data_in;
  logic        uart_busy;
  logic [3:0]  ack, grant;
  logic [7:0]  uart_data;
  logic        uart_in, timeout;

  always #5 clk = ~clk;

  uart_tx_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .req(req), .last(last), .data_in(data_in),
    .uart_busy(uart_busy), .ack(ack), .grant(grant), .uart_data(uart_data),
    .uart_in(uart_in), .timeout(timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester byte buffers {last, byte}, and the scoreboard {id, byte}.
  logic [8:0]  rbuf [4][16];
  int unsigned rhead [4];
  int unsigned rtail [4];
  logic [9:0]  exp_q [$];

  task automatic load(input int k, input logic [7:0] b, input logic lst);
    rbuf[k][rtail[k] % 16] = {lst, b};
    rtail[k]++;
  endtask

  task automatic push_exp(input int k, input logic [7:0] b);
    exp_q.push_back({2'(k), b});
  endtask

  // Monitor, requester drivers and UART busy model, all on the falling edge.
  int unsigned busy_cnt;
  logic        prev_in;
  initial begin
    logic [9:0] e;
    logic       have;
    for (int k = 0; k < 4; k++) begin
      rhead[k] = 0;
      rtail[k] = 0;
    end
    req = '0; last = '0; data_in = '0; uart_busy = 1'b0;
    busy_cnt = 0; prev_in = 1'b0;
    forever begin
      @(negedge clk);
      check_eq("ack_only_with_strobe", 32'(|ack), 32'(uart_in));
      if (uart_in) begin
        check_eq("strobe_width", 32'(prev_in), 0);
        check_eq("busy_at_strobe", 32'(uart_busy), 0);
        have = (exp_q.size() != 0);
        check_eq("sb_pending", 32'(have), 1);
        if (have) begin
          e = exp_q.pop_front();
          check_eq("strobe_data", 32'(uart_data), 32'(e[7:0]));
          check_eq("strobe_ack", 32'(ack), 32'(4'b0001 << e[9:8]));
          check_eq("strobe_grant", 32'(grant), 32'(4'b0001 << e[9:8]));
        end
      end
      prev_in = uart_in;
      for (int k = 0; k < 4; k++)
        if (ack[k] && rhead[k] != rtail[k]) rhead[k]++;
      if (uart_in) busy_cnt = BUSY_LEN;
      else if (busy_cnt != 0) busy_cnt--;
      uart_busy = (busy_cnt != 0);
      for (int k = 0; k < 4; k++) begin
        if (rhead[k] != rtail[k]) begin
          req[k]           = 1'b1;
          last[k]          = rbuf[k][rhead[k] % 16][8];
          data_in[8*k +: 8] = rbuf[k][rhead[k] % 16][7:0];
        end else begin
          req[k]  = 1'b0;
          last[k] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_free(input string tag);
    int unsigned n = 0;
    while (grant != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(grant), 0);
  endtask

  task automatic wait_sent(input int k, input string tag);
    int unsigned n = 0;
    while (rhead[k] != rtail[k] && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, rtail[k] - rhead[k], 0);
  endtask

  task automatic wait_idle_uart(input string tag);
    int unsigned n = 0;
    while (uart_busy && n < 100) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(uart_busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 0);
    check_eq({tag, "_grant"}, 32'(grant), 0);
    check_eq({tag, "_data"}, 32'(uart_data), 0);
    check_eq({tag, "_in"}, 32'(uart_in), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    int unsigned n;
    int unsigned bad;
    nRst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    nRst = 1'b1;
    tick();

    // All four request at once, twice: order 0..3 both times.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        load(k, 8'(8'hA0 + 8'(16 * r) + 8'(k)), 1'b1);
        push_exp(k, 8'(8'hA0 + 8'(16 * r) + 8'(k)));
      end
      wait_drain("rr_drained");
      wait_free("rr_free");
    end

    // Requester 2 packet of three bytes; requester 0 waits throughout.
    load(2, 8'h11, 1'b0);
    load(2, 8'h22, 1'b0);
    load(2, 8'h33, 1'b1);
    push_exp(2, 8'h11); push_exp(2, 8'h22); push_exp(2, 8'h33); push_exp(0, 8'h55);
    n = 0;
    while (exp_q.size() != 3 && n < 50) begin tick(); n++; end
    check_eq("pkt_first_byte", 32'(exp_q.size()), 3);
    load(0, 8'h55, 1'b1);
    wait_drain("pkt_drained");
    wait_free("pkt_free");

    // Requester 1 two single-byte packets back to back.
    load(1, 8'hA5, 1'b1); push_exp(1, 8'hA5);
    load(1, 8'h5A, 1'b1); push_exp(1, 8'h5A);
    wait_drain("r1_drained");
    wait_free("r1_free");

    // Requester 3 opens a packet then goes quiet; 0 and 2 wait.
    load(3, 8'h77, 1'b0); push_exp(3, 8'h77);
    wait_sent(3, "lock_first_sent");
`ifdef UART_TX_ARB_TIMEOUT_EN
    push_exp(0, 8'hC0); push_exp(2, 8'hC2);
    load(0, 8'hC0, 1'b1); load(2, 8'hC2, 1'b1);
    n = 0;
    while (grant != 0 && n < 300) begin tick(); n++; end
    check_eq("lock_release_cycles", n, BUSY_LEN + 1 + TO);
    check_eq("timeout_set", 32'(timeout), 1);
`else
    push_exp(3, 8'h78); push_exp(0, 8'hC0); push_exp(2, 8'hC2);
    load(0, 8'hC0, 1'b1); load(2, 8'hC2, 1'b1);
    bad = 0;
    repeat (1000) begin
      tick();
      if (grant !== 4'b1000) bad++;
    end
    check_eq("lock_hold", bad, 0);
    check_eq("timeout_clear", 32'(timeout), 0);
    check_eq("lock_none_served", 32'(exp_q.size()), 3);
    load(3, 8'h78, 1'b1);
`endif
    wait_drain("lock_drained");
    wait_free("lock_free");
    wait_idle_uart("lock_uart_idle");

    // Reset while a locked packet is in WAIT.
    load(1, 8'h99, 1'b0); push_exp(1, 8'h99);
    wait_sent(1, "rst_first_sent");
    repeat (3) tick();
    nRst = 1'b0;
    tick();
    check_all_zero("midrst");
    nRst = 1'b1;
    wait_idle_uart("midrst_uart_idle");
    load(1, 8'hB1, 1'b1); load(2, 8'hB2, 1'b1);
    push_exp(1, 8'hB1); push_exp(2, 8'hB2);
    wait_drain("post_rst_drained");
    wait_free("post_rst_free");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
